fsm_seq_ctrl: RTL

- Run-length stimulus sequencer and monitor for the A/K1/K2 control FSM.
- Plays a programmed table of (level, length) segments onto the FSM's A input, then raises a done pulse.
- Counts rising edges on K1 and K2 during the run, so the FSM can be exercised on-chip without a bench.
- Sits between a host/config interface and the fsm instance.

---
 rtl/fsm_seq_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fsm_seq_ctrl.sv
// Run-length stimulus sequencer for the A/K1/K2 FSM: plays a (level, length) table onto A
// and counts K1/K2 rising edges during the run. Optional endless looping under FSM_SEQ_LOOP_EN.
module fsm_seq_ctrl #(
  parameter int SEG_AW = 3,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [SEG_AW-1:0] cfg_addr,
  input  logic              cfg_level,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [SEG_AW:0]   nseg,
  input  logic              start,
  input  logic              abort,
`ifdef FSM_SEQ_LOOP_EN
  input  logic              loop,
`endif
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              fsm_A,
  input  logic              fsm_K1,
  input  logic              fsm_K2,
  output logic [CNT_W-1:0]  k1_cnt,
  output logic [CNT_W-1:0]  k2_cnt
);

  localparam int NSEG = 2**SEG_AW;
  localparam logic [SEG_AW:0] NSEG_V = (SEG_AW+1)'(NSEG);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_lvl [NSEG];
  logic [LEN_W-1:0]    r_len [NSEG];
  logic [SEG_AW-1:0]   r_seg_idx, w_seg_idx_nxt;
  logic [LEN_W-1:0]    r_len_cnt, w_len_cnt_nxt;
  logic [SEG_AW:0]     r_eff_nseg, w_eff_nseg_nxt;
  logic                r_a, w_a_nxt;
  logic                r_aborted, w_aborted_nxt;
  logic                r_loop, w_loop_nxt;
  logic                w_loop_in;
  logic                w_clr_cnt;
  logic [SEG_AW:0]     w_nseg_clamp;
  logic [SEG_AW-1:0]   w_seg_inc;
  logic                w_last;
  logic                r_k1_q, r_k1_prev, r_k2_q, r_k2_prev;
  logic [CNT_W-1:0]    r_k1_cnt, r_k2_cnt;
  logic                w_k1_edge, w_k2_edge;

`ifdef FSM_SEQ_LOOP_EN
  assign w_loop_in = loop;
`else
  assign w_loop_in = 1'b0;
`endif

  // A zero length still plays for one cycle, so the down-counter starts at max(len,1)-1.
  function automatic logic [LEN_W-1:0] f_reload(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  assign w_nseg_clamp = (nseg > NSEG_V) ? NSEG_V : nseg;
  assign w_seg_inc    = r_seg_idx + 1'b1;
  assign w_last       = ({1'b0, r_seg_idx} == (r_eff_nseg - 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_seg_idx  <= '0;
      r_len_cnt  <= '0;
      r_eff_nseg <= '0;
      r_a        <= 1'b0;
      r_aborted  <= 1'b0;
      r_loop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_seg_idx  <= w_seg_idx_nxt;
      r_len_cnt  <= w_len_cnt_nxt;
      r_eff_nseg <= w_eff_nseg_nxt;
      r_a        <= w_a_nxt;
      r_aborted  <= w_aborted_nxt;
      r_loop     <= w_loop_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_seg_idx_nxt  = r_seg_idx;
    w_len_cnt_nxt  = r_len_cnt;
    w_eff_nseg_nxt = r_eff_nseg;
    w_a_nxt        = r_a;
    w_aborted_nxt  = r_aborted;
    w_loop_nxt     = r_loop;
    w_clr_cnt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_a_nxt = 1'b0;
        if (start) begin
          w_clr_cnt      = 1'b1;
          w_aborted_nxt  = 1'b0;
          w_eff_nseg_nxt = w_nseg_clamp;
          w_loop_nxt     = w_loop_in;
          if (w_nseg_clamp == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt   = S_PLAY;
            w_seg_idx_nxt = '0;
            w_len_cnt_nxt = f_reload(r_len[0]);
            w_a_nxt       = r_lvl[0];
          end
        end
      end
      S_PLAY: begin
        if (abort) begin
          w_state_nxt   = S_DONE;
          w_a_nxt       = 1'b0;
          w_aborted_nxt = 1'b1;
        end else if (r_len_cnt == '0) begin
          if (w_last && !r_loop) begin
            w_state_nxt = S_DONE;
            w_a_nxt     = 1'b0;
          end else if (w_last) begin
            w_seg_idx_nxt = '0;
            w_len_cnt_nxt = f_reload(r_len[0]);
            w_a_nxt       = r_lvl[0];
          end else begin
            w_seg_idx_nxt = w_seg_inc;
            w_len_cnt_nxt = f_reload(r_len[w_seg_inc]);
            w_a_nxt       = r_lvl[w_seg_inc];
          end
        end else begin
          w_len_cnt_nxt = r_len_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_a_nxt     = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_a_nxt     = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The table is frozen while a run is playing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        r_lvl[i] <= 1'b0;
        r_len[i] <= '0;
      end
    end else if (cfg_we && (r_state != S_PLAY)) begin
      r_lvl[cfg_addr] <= cfg_level;
      r_len[cfg_addr] <= cfg_len;
    end
  end

  assign w_k1_edge = r_k1_q & ~r_k1_prev;
  assign w_k2_edge = r_k2_q & ~r_k2_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k1_q    <= 1'b0;
      r_k1_prev <= 1'b0;
      r_k2_q    <= 1'b0;
      r_k2_prev <= 1'b0;
      r_k1_cnt  <= '0;
      r_k2_cnt  <= '0;
    end else begin
      r_k1_q    <= fsm_K1;
      r_k1_prev <= r_k1_q;
      r_k2_q    <= fsm_K2;
      r_k2_prev <= r_k2_q;
      if (w_clr_cnt) begin
        r_k1_cnt <= '0;
        r_k2_cnt <= '0;
      end else if (r_state == S_PLAY) begin
        if (w_k1_edge && (r_k1_cnt != '1)) r_k1_cnt <= r_k1_cnt + 1'b1;
        if (w_k2_edge && (r_k2_cnt != '1)) r_k2_cnt <= r_k2_cnt + 1'b1;
      end
    end
  end

  assign busy    = (r_state == S_PLAY);
  assign done    = (r_state == S_DONE);
  assign aborted = r_aborted;
  assign fsm_A   = r_a;
  assign k1_cnt  = r_k1_cnt;
  assign k2_cnt  = r_k2_cnt;

endmodule
